// File: rtl/bram_march_tester_pkg.sv
// bram_march_tester_pkg: shared state encoding, counter width and test-pattern generator.
package bram_march_tester_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    localparam int ERR_CNT_W = 16;
    localparam int PAT_W     = 36;

    // Address replicated across the word, then xored with seed, channel index and pass polarity.
    function automatic logic [PAT_W-1:0] pat(input int ch, input logic [31:0] addr,
                                              input logic [PAT_W-1:0] seed, input logic p,
                                              input int addr_w);
        logic [PAT_W-1:0] base;
        for (int i = 0; i < PAT_W; i++) base[i] = addr[5'(i % addr_w)];
        return base ^ seed ^ PAT_W'(ch) ^ {PAT_W{p}};
    endfunction

endpackage

// File: rtl/bram_march_tester_sp_ch.sv
// bram_sp_ch: single-port synchronous RAM channel, READ_LAT 1 (no output reg) or 2 (output reg).
module bram_sp_ch #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 9,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
`ifdef SYNTHESIS
    logic [8:0] w_doa;
    (* keep *) EG_PHY_BRAM #(
        .MODE("SP8K"), .DATA_WIDTH_A("9"), .WRITEMODE_A("NORMAL"),
        .REGMODE_A(READ_LAT == 2 ? "OUTREG" : "NOREG")
    ) u_bram (
        .clka(clk), .cea(1'b1), .ocea(1'b1), .rsta(1'b0), .csa(3'b111), .wea(i_we),
        .addra(13'({i_addr, 3'b000})), .dia(9'(i_wdata)), .doa(w_doa),
        .clkb(1'b0), .ceb(1'b0), .oceb(1'b0), .rstb(1'b0), .csb(3'b000), .web(1'b0),
        .addrb(13'd0), .dib(9'd0), .dob()
    );
    assign o_rdata = w_doa[DATA_W-1:0];
`else
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_q <= r_mem[i_addr];
    end
    if (READ_LAT == 2) begin : g_oreg
        logic [DATA_W-1:0] r_q2;
        always_ff @(posedge clk) r_q2 <= r_q;
        assign o_rdata = r_q2;
    end else begin : g_noreg
        assign o_rdata = r_q;
    end
`endif
endmodule

// File: rtl/bram_march_tester.sv
// bram_march_tester: two-pass write/readback march over NUM_CH parallel RAM channels,
// reporting per-channel fail flags, a saturating error count and the first failing address.
module bram_march_tester
    import bram_march_tester_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 9,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DATA_W-1:0]    seed,
    input  logic                 inject_en,
    input  logic [ADDR_W-1:0]    inject_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_CH-1:0]    fail_mask,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_addr
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int EW    = READ_LAT * ADDR_W;
    localparam int POP_W = $clog2(NUM_CH + 1);

    state_t                     r_state, w_next;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_pass_idx, r_inj_en;
    logic [DATA_W-1:0]          r_seed;
    logic [ADDR_W-1:0]          r_inj_addr, r_first;
    logic [READ_LAT-1:0]        r_vld;
    logic [EW-1:0]              r_eaddr;
    logic [NUM_CH-1:0]          r_fail;
    logic [ERR_CNT_W-1:0]       r_err;
    logic                       w_accept, w_wr_last, w_rd_last, w_issue, w_cmp;
    logic [ADDR_W-1:0]          w_addr, w_eaddr;
    logic [NUM_CH-1:0]          w_mis;
    logic [POP_W-1:0]           w_pop;
    logic [ERR_CNT_W:0]         w_sum;
    logic [NUM_CH-1:0][DATA_W-1:0] w_wdata, w_rdata;

    assign w_addr    = r_cnt[ADDR_W-1:0];
    assign w_eaddr   = r_eaddr[EW-1 -: ADDR_W];
    assign w_accept  = (r_state == S_IDLE || r_state == S_DONE) && start && !abort;
    assign w_wr_last = r_state == S_WRITE && w_addr == '1;
    assign w_rd_last = r_state == S_READ && r_cnt == CNT_W'(DEPTH + READ_LAT - 1);
    assign w_issue   = r_state == S_READ && !r_cnt[ADDR_W];
    assign w_cmp     = r_state == S_READ && r_vld[READ_LAT-1] && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = start ? S_WRITE : r_state;
            S_WRITE:        w_next = w_wr_last ? S_READ : S_WRITE;
            S_READ:         w_next = w_rd_last ? (r_pass_idx ? S_DONE : S_WRITE) : S_READ;
            default:        w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) w_pop = w_pop + POP_W'(w_mis[i]);
        w_sum = {1'b0, r_err} + (ERR_CNT_W + 1)'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_pass_idx <= 1'b0;
            r_inj_en   <= 1'b0;
            r_seed     <= '0;
            r_inj_addr <= '0;
            r_vld      <= '0;
            r_eaddr    <= '0;
            r_fail     <= '0;
            r_err      <= '0;
            r_first    <= '0;
        end else begin
            r_vld   <= READ_LAT'({r_vld, w_issue});
            r_eaddr <= EW'({r_eaddr, w_addr});
            if (w_accept || w_wr_last || w_rd_last || abort) r_cnt <= '0;
            else if (r_state == S_WRITE || r_state == S_READ) r_cnt <= r_cnt + 1'b1;
            if (w_accept) begin
                r_seed     <= seed;
                r_inj_en   <= inject_en;
                r_inj_addr <= inject_addr;
                r_pass_idx <= 1'b0;
                r_fail     <= '0;
                r_err      <= '0;
                r_first    <= '0;
            end else begin
                if (w_rd_last) r_pass_idx <= 1'b1;
                if (w_cmp) begin
                    r_fail <= r_fail | w_mis;
                    r_err  <= w_sum[ERR_CNT_W] ? '1 : w_sum[ERR_CNT_W-1:0];
                    if (r_fail == '0 && w_mis != '0) r_first <= w_eaddr;
                end
            end
        end
    end

    // Expected data is regenerated from the delayed address rather than pipelined per channel.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] w_pat, w_exp;
        assign w_pat      = DATA_W'(pat(c, 32'(w_addr), PAT_W'(r_seed), r_pass_idx, ADDR_W));
        assign w_exp      = DATA_W'(pat(c, 32'(w_eaddr), PAT_W'(r_seed), r_pass_idx, ADDR_W));
        assign w_wdata[c] = w_pat ^ DATA_W'(c == 0 && r_inj_en && w_addr == r_inj_addr);
        assign w_mis[c]   = w_rdata[c] != w_exp;
        bram_sp_ch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_ram (
            .clk(clk), .i_we(r_state == S_WRITE), .i_addr(w_addr),
            .i_wdata(w_wdata[c]), .o_rdata(w_rdata[c])
        );
    end

    assign busy           = r_state == S_WRITE || r_state == S_READ;
    assign done           = r_state == S_DONE;
    assign pass           = done && r_fail == '0;
    assign fail_mask      = r_fail;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule

// File: doc/bram_march_tester.md
Name: bram_march_tester

Overview:
- Parametrised, self-checking successor to the fixed primitive-fill tilegrid minitests.
- Instantiates NUM_CH block-RAM channels and runs a two-pass write/readback pattern on all of them in parallel.
- Reports per-channel pass/fail, error count and first failing address.
- Used on hardware to confirm that placed BRAM sites are functional, not merely present in the bitstream.

Parameters:
- NUM_CH, 8, number of independent RAM channels (1..64).
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words per channel.
- DATA_W, 9, word width (1..36).
- READ_LAT, 1, RAM read latency in cycles (1 or 2; 2 = output register enabled).

Ports:
- clk  in  1  single clock for all logic and RAMs.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- abort  in  1  synchronous abort to IDLE; overrides start.
- seed  in  DATA_W  pattern seed; captured when start is accepted.
- inject_en  in  1  fault injection enable; captured with seed.
- inject_addr  in  ADDR_W  address corrupted when inject_en is set; captured with seed.
- busy  out  1  high in WRITE/READ states.
- done  out  1  level; high in DONE until next accepted start, abort or rst.
- pass  out  1  done && (fail_mask == 0).
- fail_mask  out  NUM_CH  sticky per-channel mismatch flags.
- err_count  out  16  total mismatching words across all channels; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; captured registers 0.
- States: IDLE -> WRITE -> READ -> (WRITE for pass 1 | DONE); DONE -> WRITE on start.
- Start handling:
  - When start is accepted, clear fail_mask, err_count and first_err_addr, and set pass_idx = 0.
  - busy rises on the following edge.
- Pattern:
  - base = addr replicated and truncated to DATA_W.
  - pat(ch, addr, p) = base ^ seed_q ^ ch[DATA_W-1:0] ^ (p ? all-ones : 0).
- WRITE: one address per cycle, 0..DEPTH-1, all channels written together. Takes DEPTH cycles.
- Fault injection: if inject_en_q, channel 0 at inject_addr_q has bit 0 inverted on write. Applies in both passes.
- READ:
  - Issue addresses 0..DEPTH-1, one per cycle.
  - Expected data and address are delayed READ_LAT stages and compared with the RAM output.
  - State exits after the last compare, i.e. DEPTH + READ_LAT cycles.
- Per-cycle error accounting:
  - err_count += popcount of mismatching channels, saturating.
  - fail_mask |= mismatch vector.
  - first_err_addr is latched on the first cycle with any mismatch only.
- Timing: total busy time = 2 * (2*DEPTH + READ_LAT) cycles. done rises on the edge after the last compare of pass 1.
- start while busy: ignored.
- abort in any state:
  - Next state is IDLE; busy = 0, done = 0.
  - Result registers hold their values but are not valid.
  - abort and start in the same cycle: abort wins.
- rst mid-operation: immediate return to reset values. RAM contents are don't-care.
- Address counters wrap at DEPTH-1 into the state transition; no extra cycle is spent.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, WRITE, READ, DONE).
  - ERR_CNT_W = 16 constant.
  - Pattern-generation function pat(ch, addr, seed, p).
- Sub-module bram_sp_ch: one single-port synchronous RAM with parameter READ_LAT.
  - Behavioural array in simulation.
  - (* keep *) EG_PHY_BRAM instance under a synthesis define.
- Instantiated NUM_CH times by generate loop.

Test Plan:
- Clean run, NUM_CH=4, ADDR_W=4, DATA_W=9, READ_LAT=1, seed=9'h0A5, start pulse -> busy for 66 cycles, then done=1, pass=1, fail_mask=0, err_count=0.
- Injection, inject_en=1, inject_addr=4'd7, same config -> fail_mask=4'b0001, err_count=2 (one per pass), first_err_addr=7, pass=0.
- READ_LAT=2, ADDR_W=3, NUM_CH=2 -> busy for 2*(16+2)=36 cycles; pass=1; no off-by-one mismatches.
- Abort asserted in READ of pass 0 (start and abort together earlier) -> busy drops next edge, done=0. Restart with start -> full clean run passes; error fields were cleared at restart.
- Async rst asserted mid-WRITE, off clock edge -> all outputs 0 immediately. The next start completes normally.
- Saturation: force the RAM model to return constant data, ADDR_W=10, NUM_CH=64 -> err_count stays 16'hFFFF and does not wrap; fail_mask all ones.
